alu_uart_ctrl: RTL and testbench
================================

# alu_uart_ctrl

Packet controller between the UART receiver's AXI-Stream output and the UART transmitter's AXI-Stream input on the iCE40 UART ALU design.
- Parses framed command packets arriving byte-by-byte.
- Echoes the payload, or runs 32-bit add/subtract over little-endian operands.
- Serializes the result or an error code back to the transmitter.
- Replaces the direct rx→tx loopback in the top level.

## Interface
Parameters:
- OPERAND_WIDTH, 32: operand/result width in bits; must be a multiple of 8.
- TIMEOUT_CYCLES, 100000: inter-byte idle limit, used only with the timeout feature.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-high.
- s_axis_tdata  in  8  byte from uart_rx.
- s_axis_tvalid  in  1  rx byte valid.
- s_axis_tready  out  1  controller accepts rx byte.
- m_axis_tdata  out  8  byte to uart_tx.
- m_axis_tvalid  out  1  tx byte valid.
- m_axis_tready  in  1  uart_tx accepts byte.
- busy  out  1  high whenever a packet is in progress (any state other than HDR with zero header bytes taken).
- err  out  1  one-cycle pulse when an error response or timeout abort occurs.

## Operation
- Packet format: opcode, reserved, len_lo, len_hi, then payload. len is 16-bit little-endian and is the total byte count including the 4-byte header.
- Opcodes:
  - 0xEC ECHO.
  - 0x8A ADD.
  - 0x8B SUB.
  - All others are invalid.
- States: HDR, ECHO, ACCUM, DRAIN, RESP.
- HDR:
  - s_axis_tready=1; a byte is taken on each handshake.
  - After the 4th byte, the next state is decided from the opcode and len:
    - len<4: treated as a header-only packet; go to RESP with the error byte.
    - len==4: ECHO returns to HDR; ADD/SUB go to RESP with the error byte (no operand).
    - ECHO: go to ECHO.
    - ADD/SUB with (len−4) a nonzero multiple of 4: go to ACCUM.
    - Invalid opcode or bad ADD/SUB length: go to DRAIN.
- ECHO:
  - Combinational pass-through: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
  - Counts len−4 transfers, then returns to HDR.
- ACCUM:
  - s_axis_tready=1.
  - Assembles 4 bytes little-endian into an operand.
  - The first operand loads the accumulator.
  - Each later operand is added (ADD) or subtracted from the accumulator (SUB), mod 2^32; no overflow flag.
  - After the last payload byte, go to RESP with the accumulator.
- DRAIN:
  - s_axis_tready=1; discards the remaining len−4 bytes.
  - Then goes to RESP with the error byte.
- RESP:
  - s_axis_tready=0.
  - Sends either the 4 result bytes LSB first, or the single byte 0xEE.
  - err pulses on the cycle RESP is entered with an error.
- Remaining byte counter is 16 bits and never underflows; transitions occur at count==1 on a handshake.

## Timing
- Reset values:
  - s_axis_tready=0 while rst is high, 1 from the first cycle after release (HDR).
  - m_axis_tvalid=0, m_axis_tdata=0x00, busy=0, err=0.
  - Accumulator and counters are cleared.
- Latency:
  - A 4th header byte handshake in cycle N puts the controller in its next state in N+1.
  - The last operand handshake in N gives m_axis_tvalid=1 with result byte0 in N+1.
- RESP handshake:
  - m_axis_tdata and m_axis_tvalid are registered and held stable until m_axis_tready.
  - The next byte is presented the cycle after each handshake.
  - After the final byte handshake, the controller is in HDR the next cycle.
- No rx byte is accepted in RESP; uart_rx buffers or overruns, and that is its own concern.
- Reset mid-packet aborts immediately to HDR, with outputs at their reset values.

## Configuration
- ALU_UART_TIMEOUT_EN defined:
  - In HDR (with ≥1 header byte taken), ACCUM, DRAIN and ECHO, a counter runs while no rx handshake occurs.
  - Reaching TIMEOUT_CYCLES discards the partial packet, returns to HDR, pulses err, and transmits nothing.
  - Any rx handshake clears the counter.
- ALU_UART_TIMEOUT_EN undefined:
  - No counter logic.
  - Partial packets wait indefinitely.

## Structure
- Package alu_uart_pkg holds:
  - the opcode enum (ECHO, ADD, SUB);
  - the state enum;
  - ERR_BYTE=8'hEE;
  - HDR_LEN=4.
- One sub-module, alu_resp_ser: loads a 32-bit word or a single byte and emits it on an AXI-Stream byte interface, LSB first, and signals done.

## Test plan
- ECHO: EC 00 06 00 41 42 → tx 41 42 only; busy low after the last handshake.
- ADD: 8A 00 0C 00 01 00 00 00 02 00 00 00 → tx 03 00 00 00.
- ADD wrap: 8A 00 0C 00 FF FF FF FF 02 00 00 00 → tx 01 00 00 00.
- SUB: 8B 00 0C 00 0A 00 00 00 03 00 00 00 → tx 07 00 00 00.
- Bad opcode: 55 00 06 00 AA BB → both bytes drained, tx EE once, err pulses once.
- Backpressure and reset:
  - Hold m_axis_tready low for 5 cycles during RESP → tdata stable.
  - Assert rst mid-RESP → tvalid 0 immediately; the next ADD packet still gives the correct result.
  - With ALU_UART_TIMEOUT_EN: stall after 2 header bytes → err pulse and no tx output.

Source files
------------

// File: rtl/alu_uart_pkg.sv
// alu_uart_pkg: shared opcode/state encodings and packet constants for the
// UART ALU packet controller.
package alu_uart_pkg;

   typedef enum logic [7:0] {
      OP_ECHO = 8'hEC,
      OP_ADD  = 8'h8A,
      OP_SUB  = 8'h8B
   } opcode_t;

   typedef enum logic [2:0] {
      ST_HDR,
      ST_ECHO,
      ST_ACCUM,
      ST_DRAIN,
      ST_RESP
   } state_t;

   localparam logic [7:0]  ERR_BYTE = 8'hEE;
   localparam logic [15:0] HDR_LEN  = 16'd4;

endpackage

// File: rtl/alu_uart_if.sv
// alu_uart_if: AXI-Stream byte channel (tdata/tvalid/tready).
interface alu_uart_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/alu_resp_ser.sv
// alu_resp_ser: loads a result word or a single error byte and emits it
// LSB first on an AXI-Stream byte output; done marks the final handshake.
module alu_resp_ser
   import alu_uart_pkg::*;
#(
   parameter int unsigned OPERAND_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_word,
   input  logic                     load_err,
   input  logic [OPERAND_WIDTH-1:0] word,
   output logic [7:0]               tdata,
   output logic                     tvalid,
   input  logic                     tready,
   output logic                     done
);

   localparam int unsigned NB = OPERAND_WIDTH / 8;

   logic [OPERAND_WIDTH-1:0] sr;
   logic [15:0]              left;

   assign done = tvalid && tready && (left == 16'd1);

   // Output byte register and shift register; byte i+1 appears after handshake i.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr     <= '0;
         left   <= '0;
         tdata  <= '0;
         tvalid <= 1'b0;
      end else if (load_word) begin
         tdata  <= word[7:0];
         sr     <= word >> 8;
         left   <= 16'(NB);
         tvalid <= 1'b1;
      end else if (load_err) begin
         tdata  <= ERR_BYTE;
         sr     <= '0;
         left   <= 16'd1;
         tvalid <= 1'b1;
      end else if (tvalid && tready) begin
         left <= left - 16'd1;
         if (left == 16'd1) begin
            tvalid <= 1'b0;
         end else begin
            tdata <= sr[7:0];
            sr    <= sr >> 8;
         end
      end
   end

endmodule

// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: packet controller between uart_rx and uart_tx streams.
// Parses opcode/reserved/len header, echoes payload or runs add/sub over
// little-endian operands, and returns the result or an error byte.
// Optional inter-byte timeout abort: define ALU_UART_TIMEOUT_EN.
module alu_uart_ctrl
   import alu_uart_pkg::*;
#(
   parameter int unsigned OPERAND_WIDTH  = 32,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic      clk,
   input  logic      rst,
   alu_uart_if.slave  s_axis,
   alu_uart_if.master m_axis,
   output logic      busy,
   output logic      err
);

   localparam int unsigned NB       = OPERAND_WIDTH / 8;
   localparam logic [15:0] NB16     = 16'(NB);
   localparam logic [7:0]  LAST_IDX = 8'(NB - 1);

   if (OPERAND_WIDTH == 0 || (OPERAND_WIDTH % 8) != 0) begin : g_bad_width
      $error("OPERAND_WIDTH must be a nonzero multiple of 8");
   end
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be nonzero");
   end

   state_t                   state;
   state_t                   hdr_dest;
   logic [1:0]               hdr_cnt;
   logic [7:0]               opc;
   logic [7:0]               len_lo;
   logic [15:0]              len_full;
   logic [15:0]              payload;
   logic [15:0]              remaining;
   logic [7:0]               byte_idx;
   logic                     first;
   logic [OPERAND_WIDTH-1:0] acc;
   logic [OPERAND_WIDTH-1:0] acc_next;
   logic [OPERAND_WIDTH-1:0] opnd_sr;
   logic [OPERAND_WIDTH-1:0] opnd_full;
   logic                     s_rdy;
   logic                     s_hs;
   logic                     hdr_done;
   logic                     err_entry;
   logic                     ser_load_word;
   logic [7:0]               ser_tdata;
   logic                     ser_tvalid;
   logic                     ser_done;
`ifdef ALU_UART_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0]            to_cnt;
   logic                   to_active;
`endif

   assign s_hs      = s_axis.tvalid && s_rdy;
   assign len_full  = {s_axis.tdata, len_lo};
   assign payload   = len_full - HDR_LEN;
   assign hdr_done  = (state == ST_HDR) && s_hs && (hdr_cnt == 2'd3);
   assign opnd_full = OPERAND_WIDTH'({s_axis.tdata, opnd_sr} >> 8);
   assign busy      = !((state == ST_HDR) && (hdr_cnt == 2'd0));

   // rx ready per state; ECHO ties rx readiness to tx readiness.
   always_comb begin
      s_rdy = 1'b0;
      unique case (state)
         ST_HDR, ST_ACCUM, ST_DRAIN: s_rdy = 1'b1;
         ST_ECHO:                    s_rdy = m_axis.tready;
         ST_RESP:                    s_rdy = 1'b0;
      endcase
      s_axis.tready = s_rdy && !rst;
   end

   // Destination after the 4th header byte; len<4 is a header-only packet,
   // and a bodiless invalid opcode errors directly since there is nothing to drain.
   always_comb begin
      hdr_dest = ST_DRAIN;
      if (len_full < HDR_LEN) begin
         hdr_dest = ST_RESP;
      end else if (len_full == HDR_LEN) begin
         hdr_dest = (opc == OP_ECHO) ? ST_HDR : ST_RESP;
      end else if (opc == OP_ECHO) begin
         hdr_dest = ST_ECHO;
      end else if ((opc == OP_ADD || opc == OP_SUB) && ((payload % NB16) == '0)) begin
         hdr_dest = ST_ACCUM;
      end
   end

   // Accumulator update for the operand completing on this handshake.
   always_comb begin
      if (first) begin
         acc_next = opnd_full;
      end else if (opc == OP_SUB) begin
         acc_next = acc - opnd_full;
      end else begin
         acc_next = acc + opnd_full;
      end
   end

   // Serializer loads happen on the completing handshake so byte0 shows next cycle.
   always_comb begin
      err_entry     = (hdr_done && hdr_dest == ST_RESP) ||
                      ((state == ST_DRAIN) && s_hs && (remaining == 16'd1));
      ser_load_word = (state == ST_ACCUM) && s_hs && (byte_idx == LAST_IDX) &&
                      (remaining == 16'd1);
   end

   // ECHO passes rx straight to tx; otherwise tx comes from the serializer.
   assign m_axis.tdata  = (state == ST_ECHO) ? s_axis.tdata  : ser_tdata;
   assign m_axis.tvalid = (state == ST_ECHO) ? s_axis.tvalid : ser_tvalid;

   alu_resp_ser #(.OPERAND_WIDTH(OPERAND_WIDTH)) u_ser (
      .clk       (clk),
      .rst       (rst),
      .load_word (ser_load_word),
      .load_err  (err_entry),
      .word      (acc_next),
      .tdata     (ser_tdata),
      .tvalid    (ser_tvalid),
      .tready    (m_axis.tready && (state == ST_RESP)),
      .done      (ser_done)
   );

`ifdef ALU_UART_TIMEOUT_EN
   assign to_active = ((state == ST_HDR) && (hdr_cnt != 2'd0)) ||
                      (state == ST_ACCUM) || (state == ST_DRAIN) || (state == ST_ECHO);
`endif

   // Packet FSM: header parse, payload handling, response wait, optional timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_HDR;
         hdr_cnt   <= '0;
         opc       <= '0;
         len_lo    <= '0;
         remaining <= '0;
         byte_idx  <= '0;
         first     <= 1'b0;
         acc       <= '0;
         opnd_sr   <= '0;
         err       <= 1'b0;
`ifdef ALU_UART_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         err <= 1'b0;
         unique case (state)
            ST_HDR: begin
               if (s_hs) begin
                  hdr_cnt <= hdr_cnt + 2'd1;
                  case (hdr_cnt)
                     2'd0:    opc    <= s_axis.tdata;
                     2'd2:    len_lo <= s_axis.tdata;
                     default: ;
                  endcase
                  if (hdr_done) begin
                     state     <= hdr_dest;
                     remaining <= payload;
                     byte_idx  <= '0;
                     first     <= 1'b1;
                     err       <= err_entry;
                  end
               end
            end
            ST_ECHO: begin
               if (s_hs) begin
                  remaining <= remaining - 16'd1;
                  if (remaining == 16'd1) state <= ST_HDR;
               end
            end
            ST_ACCUM: begin
               if (s_hs) begin
                  opnd_sr   <= opnd_full;
                  remaining <= remaining - 16'd1;
                  if (byte_idx == LAST_IDX) begin
                     byte_idx <= '0;
                     acc      <= acc_next;
                     first    <= 1'b0;
                  end else begin
                     byte_idx <= byte_idx + 8'd1;
                  end
                  if (remaining == 16'd1) state <= ST_RESP;
               end
            end
            ST_DRAIN: begin
               if (s_hs) begin
                  remaining <= remaining - 16'd1;
                  if (remaining == 16'd1) begin
                     state <= ST_RESP;
                     err   <= 1'b1;
                  end
               end
            end
            ST_RESP: begin
               if (ser_done) state <= ST_HDR;
            end
         endcase
`ifdef ALU_UART_TIMEOUT_EN
         if (to_active && !s_hs) begin
            if (to_cnt == TO_LAST) begin
               state   <= ST_HDR;
               hdr_cnt <= '0;
               err     <= 1'b1;
               to_cnt  <= '0;
            end else begin
               to_cnt <= to_cnt + 32'd1;
            end
         end else begin
            to_cnt <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// tb_alu_uart_ctrl: directed-vector bench for alu_uart_ctrl.
// Timeout step is built only when ALU_UART_TIMEOUT_EN is defined.
module tb_alu_uart_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   logic err;

   alu_uart_if s_if ();
   alu_uart_if m_if ();

   int compared   = 0;
   int mismatched = 0;
   int err_cnt    = 0;
   int e0;
   logic [7:0] rx_q[$];
   logic [7:0] pkt[$];

   alu_uart_ctrl #(.OPERAND_WIDTH(32), .TIMEOUT_CYCLES(50)) dut (
      .clk    (clk),
      .rst    (rst),
      .s_axis (s_if),
      .m_axis (m_if),
      .busy   (busy),
      .err    (err)
   );

   always #5 clk = ~clk;

   // Capture tx handshakes and err pulses away from the active edge.
   always @(negedge clk) begin
      if (!rst && m_if.tvalid && m_if.tready) rx_q.push_back(m_if.tdata);
      if (err) err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit got;
      got = 1'b0;
      s_if.tdata  = b;
      s_if.tvalid = 1'b1;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (s_if.tready) begin
            @(posedge clk);
            #1;
            got = 1'b1;
         end
      end
      s_if.tvalid = 1'b0;
      if (!got) begin
         compared++;
         mismatched++;
         $error("FAIL rx_accept: byte 0x%0h not accepted, expected tready within 100 cycles", b);
      end
   endtask

   task automatic send_pkt();
      foreach (pkt[i]) send_byte(pkt[i]);
   endtask

   task automatic expect_tx(input string tag, input int n, input logic [31:0] exp);
      for (int i = 0; i < 200 && rx_q.size() < n; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk({tag, "_count"}, rx_q.size(), n);
      for (int i = 0; i < n && i < rx_q.size(); i++)
         chk({tag, "_byte"}, {24'h0, rx_q[i]}, {24'h0, exp[8*i +: 8]});
      rx_q.delete();
      @(posedge clk);
      #1;
   endtask

   initial begin
      s_if.tdata  = 8'h00;
      s_if.tvalid = 1'b0;
      m_if.tready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_s_tready", s_if.tready, 0);
      chk("rst_m_tvalid", m_if.tvalid, 0);
      chk("rst_m_tdata",  m_if.tdata, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("hdr_s_tready", s_if.tready, 1);
      @(posedge clk); #1;

      // ECHO: EC 00 06 00 41 42 -> 41 42
      send_byte(8'hEC);
      chk("echo_busy_hdr", busy, 1);
      pkt = '{8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
      send_pkt();
      chk("echo_busy_done", busy, 0);
      expect_tx("echo", 2, 32'h0000_4241);

      // ECHO with len==4 returns nothing
      pkt = '{8'hEC, 8'h00, 8'h04, 8'h00};
      send_pkt();
      chk("echo_empty_busy", busy, 0);
      expect_tx("echo_empty", 0, 32'h0);

      // ADD 1+2 with first-byte latency
      pkt = '{8'h8A, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'h02, 8'h00, 8'h00, 8'h00};
      send_pkt();
      chk("add_lat_tvalid", m_if.tvalid, 1);
      chk("add_lat_tdata", m_if.tdata, 8'h03);
      chk("add_resp_tready", s_if.tready, 0);
      expect_tx("add", 4, 32'h0000_0003);
      chk("add_busy_after", busy, 0);

      // ADD wrap FFFFFFFF+2
      pkt = '{8'h8A, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h02, 8'h00, 8'h00, 8'h00};
      send_pkt();
      expect_tx("add_wrap", 4, 32'h0000_0001);

      // SUB 10-3
      pkt = '{8'h8B, 8'h00, 8'h0C, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00,
              8'h03, 8'h00, 8'h00, 8'h00};
      send_pkt();
      expect_tx("sub", 4, 32'h0000_0007);

      // SUB three operands 100-10-5 = 85
      pkt = '{8'h8B, 8'h00, 8'h10, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00,
              8'h0A, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
      send_pkt();
      expect_tx("sub3", 4, 32'h0000_0055);

      // Bad opcode: drained, EE once, one err pulse
      e0 = err_cnt;
      pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA};
      send_pkt();
      chk("badop_busy_drain", busy, 1);
      send_byte(8'hBB);
      expect_tx("badop", 1, 32'h0000_00EE);
      chk("badop_err", err_cnt - e0, 1);

      // ADD with no operand (len==4)
      e0 = err_cnt;
      pkt = '{8'h8A, 8'h00, 8'h04, 8'h00};
      send_pkt();
      expect_tx("add_noop", 1, 32'h0000_00EE);
      chk("add_noop_err", err_cnt - e0, 1);

      // Header-only packet with len<4
      e0 = err_cnt;
      pkt = '{8'hEC, 8'h00, 8'h02, 8'h00};
      send_pkt();
      expect_tx("short_len", 1, 32'h0000_00EE);
      chk("short_len_err", err_cnt - e0, 1);

      // ADD with payload not a multiple of 4: drained then EE
      e0 = err_cnt;
      pkt = '{8'h8A, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
      send_pkt();
      expect_tx("add_badlen", 1, 32'h0000_00EE);
      chk("add_badlen_err", err_cnt - e0, 1);

      // Backpressure: tdata held while tready low
      m_if.tready = 1'b0;
      pkt = '{8'h8A, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
              8'h20, 8'h00, 8'h00, 8'h00};
      send_pkt();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_tvalid", m_if.tvalid, 1);
         chk("bp_tdata", m_if.tdata, 8'h30);
      end
      @(posedge clk); #1;
      m_if.tready = 1'b1;
      expect_tx("bp", 4, 32'h0000_0030);

      // Reset during RESP, then a fresh ADD
      m_if.tready = 1'b0;
      send_pkt();
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_tvalid", m_if.tvalid, 0);
      chk("midrst_tdata", m_if.tdata, 8'h00);
      chk("midrst_s_tready", s_if.tready, 0);
      chk("midrst_busy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_if.tready = 1'b1;
      rx_q.delete();
      pkt = '{8'h8A, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
              8'h06, 8'h00, 8'h00, 8'h00};
      send_pkt();
      expect_tx("after_rst", 4, 32'h0000_000B);

`ifdef ALU_UART_TIMEOUT_EN
      // Stall after two header bytes: err pulse, no tx
      e0 = err_cnt;
      send_byte(8'h8A);
      send_byte(8'h00);
      repeat (70) @(negedge clk);
      chk("to_err", err_cnt - e0, 1);
      chk("to_no_tx", rx_q.size(), 0);
      chk("to_busy", busy, 0);
      @(posedge clk); #1;
      send_pkt();
      expect_tx("to_after", 4, 32'h0000_000B);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
